// File: rtl/player_move_if.sv
// player_move_if: bundles the button inputs, frame pulse and grid-position
// outputs of player_move_ctrl.
//   master : drives p1_btn/p2_btn/frame_tick, observes positions and flags
//   slave  : the controller (consumes buttons/frame_tick, drives positions)
// Handshake: there is no valid/ready pair here. Buttons are level signals
// sampled every clk; frame_tick is a one-cycle strobe. Outputs are
// registered and are valid in every cycle after reset.
// p1_state_dbg/p2_state_dbg expose the per-player move FSM states.
interface player_move_if;
  logic [3:0] p1_btn;
  logic [3:0] p2_btn;
  logic       frame_tick;
  logic [3:0] player_x;
  logic [3:0] player_y;
  logic [3:0] player_2x;
  logic [3:0] player_2y;
  logic       p1_win;
  logic       p2_win;
  logic       game_over;
  logic [1:0] p1_state_dbg;
  logic [1:0] p2_state_dbg;

  modport master (
    output p1_btn, p2_btn, frame_tick,
    input  player_x, player_y, player_2x, player_2y,
    input  p1_win, p2_win, game_over, p1_state_dbg, p2_state_dbg
  );

  modport slave (
    input  p1_btn, p2_btn, frame_tick,
    output player_x, player_y, player_2x, player_2y,
    output p1_win, p2_win, game_over, p1_state_dbg, p2_state_dbg
  );
endinterface

// File: rtl/player_move_ctrl.sv
// player_move_ctrl: turns raw push buttons of two players into 4-bit grid
// coordinates for the VGA display stage.
// Pipeline: 2-flop sync -> per-bit debounce -> rising-edge press pulse ->
// per-player FSM (IDLE -> WAIT_FRAME -> COOLDOWN) -> legality check ->
// position/win registers. Positions only change on frame_tick.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-low reset
//   bus  : player_move_if.slave (buttons, frame_tick, positions, win flags,
//          FSM state debug)
// Optional feature: define WRAP_X_EN to wrap horizontal moves across the
// left/right grid edges; undefined, those moves are blocked.
module player_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COOLDOWN_CYCLES = 5000000,
  parameter int START_X1        = 7,
  parameter int START_X2        = 8,
  parameter int START_Y         = 11
) (
  input  logic          clk,
  input  logic          rst,
  player_move_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, COOLDOWN} state_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] x;
    logic [3:0] y;
  } move_t;

  // ---------------- synchroniser / debounce / edge detect ----------------
  // Bits [3:0] belong to player 1, [7:4] to player 2; within a nibble
  // bit 3 = up, 2 = down, 1 = left, 0 = right.
  logic [7:0]    sync1, sync2, db, db_q;
  logic [DW-1:0] db_cnt [8];
  logic [7:0]    press;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {bus.p2_btn, bus.p1_btn};
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign press = db & ~db_q;

  // Keep only the highest-priority press: up > down > left > right.
  function automatic logic [3:0] pick(input logic [3:0] p);
    if (p[3])      pick = 4'b1000;
    else if (p[2]) pick = 4'b0100;
    else if (p[1]) pick = 4'b0010;
    else if (p[0]) pick = 4'b0001;
    else           pick = 4'b0000;
  endfunction

  function automatic logic is_tree(input logic [3:0] col);
    case (col)
      4'd0, 4'd1, 4'd3, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd13, 4'd15:
        is_tree = 1'b1;
      default: is_tree = 1'b0;
    endcase
  endfunction

  // Target is formed 5 bits wide so under/overflow shows up as a value
  // outside the grid rather than silently wrapping.
  function automatic move_t eval_move(input logic [3:0] dir,
                                      input logic [3:0] x, input logic [3:0] y,
                                      input logic [3:0] ox, input logic [3:0] oy);
    logic [4:0] tx, ty;
    logic       ok;
    tx = {1'b0, x};
    ty = {1'b0, y};
    case (dir)
      4'b1000: ty = ty - 5'd1;
      4'b0100: ty = ty + 5'd1;
      4'b0010: tx = tx - 5'd1;
      4'b0001: tx = tx + 5'd1;
      default: ;
    endcase
`ifdef WRAP_X_EN
    tx = {1'b0, tx[3:0]};
`endif
    ok = 1'b1;
    if (tx > 5'd15) ok = 1'b0;
    if (ty > 5'd11) ok = 1'b0;
    if (ty == 5'd1 && is_tree(tx[3:0])) ok = 1'b0;
    if (tx[3:0] == ox && ty[3:0] == oy) ok = 1'b0;
    eval_move = '{ok: ok, x: tx[3:0], y: ty[3:0]};
  endfunction

  // ---------------- per-player move FSMs and positions ----------------
  state_t        st1, st2;
  logic [3:0]    pend1, pend2;
  logic [CW-1:0] cd1, cd2;
  logic [3:0]    x1, y1, x2, y2;
  logic          win1, win2, go;

  move_t      m1, m2;
  logic       mv1, mv2;
  logic [3:0] nx1, ny1;

  // Player 2 is checked against player 1's post-tick tile, so player 1
  // takes a contested tile.
  always_comb begin
    m1  = eval_move(pend1, x1, y1, x2, y2);
    mv1 = (st1 == WAIT_FRAME) && bus.frame_tick && m1.ok;
    nx1 = mv1 ? m1.x : x1;
    ny1 = mv1 ? m1.y : y1;
    m2  = eval_move(pend2, x2, y2, nx1, ny1);
    mv2 = (st2 == WAIT_FRAME) && bus.frame_tick && m2.ok;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st1   <= IDLE;
      st2   <= IDLE;
      pend1 <= '0;
      pend2 <= '0;
      cd1   <= '0;
      cd2   <= '0;
      x1    <= 4'(START_X1);
      y1    <= 4'(START_Y);
      x2    <= 4'(START_X2);
      y2    <= 4'(START_Y);
      win1  <= 1'b0;
      win2  <= 1'b0;
      go    <= 1'b0;
    end else begin
      if (mv1) begin
        x1 <= m1.x;
        y1 <= m1.y;
        if (m1.y == 4'd0) win1 <= 1'b1;
      end
      if (mv2) begin
        x2 <= m2.x;
        y2 <= m2.y;
        if (m2.y == 4'd0) win2 <= 1'b1;
      end
      if ((mv1 && m1.y == 4'd0) || (mv2 && m2.y == 4'd0)) go <= 1'b1;

      case (st1)
        IDLE: if (press[3:0] != 4'd0) begin
          pend1 <= pick(press[3:0]);
          st1   <= WAIT_FRAME;
        end
        WAIT_FRAME: if (bus.frame_tick) begin
          cd1 <= CW'(COOLDOWN_CYCLES);
          st1 <= COOLDOWN;
        end
        COOLDOWN: if (cd1 == '0) st1 <= IDLE;
                  else cd1 <= cd1 - CW'(1);
        default: st1 <= IDLE;
      endcase

      case (st2)
        IDLE: if (press[7:4] != 4'd0) begin
          pend2 <= pick(press[7:4]);
          st2   <= WAIT_FRAME;
        end
        WAIT_FRAME: if (bus.frame_tick) begin
          cd2 <= CW'(COOLDOWN_CYCLES);
          st2 <= COOLDOWN;
        end
        COOLDOWN: if (cd2 == '0) st2 <= IDLE;
                  else cd2 <= cd2 - CW'(1);
        default: st2 <= IDLE;
      endcase

      // After a win both FSMs are parked; this overrides the case above.
      if (go) begin
        st1 <= IDLE;
        st2 <= IDLE;
      end
    end
  end

  assign bus.player_x     = x1;
  assign bus.player_y     = y1;
  assign bus.player_2x    = x2;
  assign bus.player_2y    = y2;
  assign bus.p1_win       = win1;
  assign bus.p2_win       = win2;
  assign bus.game_over    = go;
  assign bus.p1_state_dbg = st1;
  assign bus.p2_state_dbg = st2;

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb_player_move_ctrl: self-checking bench for player_move_ctrl with
// DEBOUNCE_CYCLES=4 and COOLDOWN_CYCLES=8. Directed scenarios use constant
// expectations; a random phase is checked against a grid-level model.
module tb_player_move_ctrl;

  localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LF = 4'b0010, RT = 4'b0001;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  player_move_if bus();

  player_move_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(8),
    .START_X1(7),
    .START_X2(8),
    .START_Y(11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model (grid level) ----------------
  int mx[2], my[2];
  bit mw[2];
  bit mgo;
  int trees[10] = '{0, 1, 3, 4, 6, 8, 10, 12, 13, 15};

  function automatic void model_reset();
    mx[0] = 7; mx[1] = 8; my[0] = 11; my[1] = 11;
    mw[0] = 0; mw[1] = 0; mgo = 0;
  endfunction

  function automatic int first_dir(input logic [3:0] m);
    if (m[3]) return 0;
    if (m[2]) return 1;
    if (m[1]) return 2;
    if (m[0]) return 3;
    return -1;
  endfunction

  // Player 1 is resolved first; player 2 then sees player 1's new tile.
  function automatic void model_tick(input logic [3:0] b1, input logic [3:0] b2);
    int d[2];
    int tx, ty, o;
    bit ok;
    if (mgo) return;
    d[0] = first_dir(b1);
    d[1] = first_dir(b2);
    for (int p = 0; p < 2; p++) begin
      if (d[p] < 0) continue;
      tx = mx[p]; ty = my[p];
      case (d[p])
        0: ty = ty - 1;
        1: ty = ty + 1;
        2: tx = tx - 1;
        default: tx = tx + 1;
      endcase
`ifdef WRAP_X_EN
      tx = (tx + 16) % 16;
`endif
      ok = (tx >= 0 && tx <= 15 && ty >= 0 && ty <= 11);
      if (ty == 1) foreach (trees[k]) if (trees[k] == tx) ok = 0;
      o = 1 - p;
      if (tx == mx[o] && ty == my[o]) ok = 0;
      if (ok) begin
        mx[p] = tx; my[p] = ty;
        if (ty == 0) mw[p] = 1;
      end
    end
    mgo = mw[0] | mw[1];
  endfunction

  function automatic logic [18:0] exp_model();
    return {4'(mx[0]), 4'(my[0]), 4'(mx[1]), 4'(my[1]), mw[0], mw[1], mgo};
  endfunction

  function automatic logic [18:0] obs();
    return {bus.player_x, bus.player_y, bus.player_2x, bus.player_2y,
            bus.p1_win, bus.p2_win, bus.game_over};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    bus.p1_btn = '0; bus.p2_btn = '0; bus.frame_tick = 1'b0;
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    model_reset();
  endtask

  // Press, release, let the press reach WAIT_FRAME, fire one frame_tick,
  // then wait 'cool' cycles.
  task automatic step(input logic [3:0] b1, input logic [3:0] b2, input int cool);
    bus.p1_btn = b1; bus.p2_btn = b2;
    tick(6);
    bus.p1_btn = '0; bus.p2_btn = '0;
    tick(10);
    bus.frame_tick = 1'b1;
    tick(1);
    bus.frame_tick = 1'b0;
    model_tick(b1, b2);
    tick(cool);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [18:0] e;
    do_reset();
    e = {4'd7, 4'd11, 4'd8, 4'd11, 3'b000};
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL reset: got %h want %h", obs(), e); end
    step(UP, 4'd0, 2);
    do_reset();
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL reset_mid_cooldown: got %h want %h", obs(), e); end
    step(UP, 4'd0, 12);
    e = {4'd7, 4'd10, 4'd8, 4'd11, 3'b000};
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL press_after_reset: got %h want %h", obs(), e); end
  endtask

  task automatic test_debounce();
    do_reset();
    bus.p1_btn = UP;
    tick(6);
    bus.p1_btn = '0;
    tick(10);
    n_cmp++;
    if (bus.player_y !== 4'd11) begin n_bad++; $display("FAIL before_frame: player_y=%0d want 11", bus.player_y); end
    bus.frame_tick = 1'b1;
    tick(1);
    bus.frame_tick = 1'b0;
    n_cmp++;
    if (bus.player_y !== 4'd10) begin n_bad++; $display("FAIL frame_latency: player_y=%0d want 10", bus.player_y); end
    tick(12);
    bus.p1_btn = UP;
    tick(2);
    bus.p1_btn = '0;
    tick(14);
    bus.frame_tick = 1'b1;
    tick(1);
    bus.frame_tick = 1'b0;
    n_cmp++;
    if (bus.player_y !== 4'd10) begin n_bad++; $display("FAIL glitch: player_y=%0d want 10", bus.player_y); end
    tick(12);
  endtask

  task automatic test_cooldown();
    do_reset();
    step(UP, 4'd0, 0);
    // Press arrives while the FSM is still cooling down.
    bus.p1_btn = UP;
    tick(6);
    bus.p1_btn = '0;
    tick(10);
    bus.frame_tick = 1'b1;
    tick(1);
    bus.frame_tick = 1'b0;
    n_cmp++;
    if (bus.player_y !== 4'd10) begin n_bad++; $display("FAIL cooldown_discard: player_y=%0d want 10", bus.player_y); end
    tick(12);
    step(UP, 4'd0, 12);
    n_cmp++;
    if (bus.player_y !== 4'd9) begin n_bad++; $display("FAIL cooldown_expired: player_y=%0d want 9", bus.player_y); end
  endtask

  task automatic test_blocking_and_win();
    logic [18:0] e;
    do_reset();
    step(4'd0, LF, 12);
    n_cmp++;
    if (bus.player_2x !== 4'd8) begin n_bad++; $display("FAIL block_other: player_2x=%0d want 8", bus.player_2x); end
    step(DN, 4'd0, 12);
    n_cmp++;
    if (bus.player_y !== 4'd11) begin n_bad++; $display("FAIL block_bottom: player_y=%0d want 11", bus.player_y); end
    for (int i = 0; i < 9; i++) step(UP, 4'd0, 12);
    for (int i = 0; i < 5; i++) step(LF, 4'd0, 12);
    e = {4'd2, 4'd2, 4'd8, 4'd11, 3'b000};
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL walk_2_2: got %h want %h", obs(), e); end
    step(UP, 4'd0, 12);
    step(LF, 4'd0, 12);
    e = {4'd2, 4'd1, 4'd8, 4'd11, 3'b000};
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL block_tree: got %h want %h", obs(), e); end
    step(UP, 4'd0, 12);
    e = {4'd2, 4'd0, 4'd8, 4'd11, 3'b101};
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL p1_win: got %h want %h", obs(), e); end
    step(DN, UP, 12);
    step(RT, LF, 12);
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL frozen_after_win: got %h want %h", obs(), e); end
  endtask

  task automatic test_contest_and_both_win();
    logic [18:0] e;
    do_reset();
    for (int i = 0; i < 7; i++) step(UP, 4'd0, 12);
    for (int i = 0; i < 2; i++) step(LF, 4'd0, 12);
    for (int i = 0; i < 7; i++) step(4'd0, UP, 12);
    step(4'd0, LF, 12);
    e = {4'd5, 4'd4, 4'd7, 4'd4, 3'b000};
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL contest_setup: got %h want %h", obs(), e); end
    step(RT, LF, 12);
    e = {4'd6, 4'd4, 4'd7, 4'd4, 3'b000};
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL same_tile: got %h want %h", obs(), e); end
    step(LF, 4'd0, 12);
    for (int i = 0; i < 3; i++) step(UP, UP, 12);
    step(UP, UP, 12);
    e = {4'd5, 4'd0, 4'd7, 4'd0, 3'b111};
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL both_win: got %h want %h", obs(), e); end
  endtask

  task automatic test_wrap();
    logic [3:0] e2x;
    do_reset();
    for (int i = 0; i < 6; i++) step(4'd0, UP, 12);
    for (int i = 0; i < 8; i++) step(4'd0, LF, 12);
    n_cmp++;
    if (bus.player_2x !== 4'd0 || bus.player_2y !== 4'd5) begin
      n_bad++; $display("FAIL wrap_setup: p2=(%0d,%0d) want (0,5)", bus.player_2x, bus.player_2y);
    end
    step(4'd0, LF, 12);
`ifdef WRAP_X_EN
    e2x = 4'd15;
`else
    e2x = 4'd0;
`endif
    n_cmp++;
    if (bus.player_2x !== e2x) begin n_bad++; $display("FAIL wrap_left: player_2x=%0d want %0d", bus.player_2x, e2x); end
  endtask

  task automatic test_random();
    logic [3:0] b1, b2;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (mgo) do_reset();
      b1 = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      b2 = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      step(b1, b2, 12);
      n_cmp++;
      if (obs() !== exp_model()) begin
        n_bad++;
        $display("FAIL random[%0d] b1=%b b2=%b: got %h want %h", i, b1, b2, obs(), exp_model());
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.p1_btn = '0;
    bus.p2_btn = '0;
    bus.frame_tick = 1'b0;
    test_reset();
    test_debounce();
    test_cooldown();
    test_blocking_and_win();
    test_contest_and_both_win();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Upstream stage of the VGA display block: turns raw push-button inputs for two players into the 4-bit grid coordinates (player_x/player_y, player_2x/player_2y) the display consumes.
- Performs synchronisation, debounce, edge detection, per-player move FSM with cooldown, legality checks (bounds, tree row, other player) and win detection.
- Positions change only on frame_tick, so the display never changes a sprite mid-frame.

Parameters:
- DEBOUNCE_CYCLES, 500000, clk cycles a raw button must hold a new level before the debounced level changes (10 ms @ 50 MHz)
- COOLDOWN_CYCLES, 5000000, clk cycles after an applied or blocked move during which new presses are discarded
- START_X1, 7, player 1 reset column
- START_X2, 8, player 2 reset column
- START_Y, 11, reset row for both players

Ports:
- clk  input  1  50 MHz system clock
- rst  input  1  reset, synchronous, active-low
- p1_btn  input  4  player 1 raw buttons {up,down,left,right}, active-high, asynchronous
- p2_btn  input  4  player 2 raw buttons, same encoding
- frame_tick  input  1  one-cycle pulse per video frame (start of vertical blank)
- player_x  output  4  player 1 column 0..15
- player_y  output  4  player 1 row 0..11
- player_2x  output  4  player 2 column
- player_2y  output  4  player 2 row
- p1_win  output  1  sticky, player 1 reached row 0
- p2_win  output  1  sticky, player 2 reached row 0
- game_over  output  1  sticky, OR of the win flags

Behaviour:
- Reset (rst==0 at a clk edge):
  - player_x=START_X1, player_2x=START_X2, player_y=player_2y=START_Y.
  - Win flags and game_over = 0; FSMs to IDLE; all counters, sync flops, debounced levels and pending registers = 0.
  - Reset mid-move or mid-cooldown aborts it.
- Synchroniser: 2-flop synchroniser per button bit (8 bits in total).
- Debounce, per bit:
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1 the debounced level takes the synced level and the counter clears.
- Edge detect: a debounced 0->1 gives a one-cycle press pulse. If several pulses for one player occur in the same cycle, priority is up>down>left>right and the rest are dropped.
- Per-player FSM:
  - IDLE: press pulse -> latch direction into pending, go to WAIT_FRAME.
  - WAIT_FRAME: presses ignored. On frame_tick, evaluate the move, update the position the same edge if legal, load the cooldown counter, go to COOLDOWN.
  - COOLDOWN: counter decrements each clk; presses are discarded; at 0 -> IDLE.
  - Latency: the position updates on the clk edge where frame_tick is sampled high in WAIT_FRAME. Outputs are registered.
- Move legality: the target is computed 5 bits wide (up: y-1, down: y+1, left: x-1, right: x+1). The move is blocked when any of these holds:
  - x underflow or x>15.
  - y underflow or y>11.
  - Target row ==1 and column in {0,1,3,4,6,8,10,12,13,15} (tree tiles).
  - Target equals the other player's tile. Player 1 is checked against player 2's pre-tick position. Player 2 is checked against player 1's post-tick position, so on a same-tile contest player 1 wins.
  - A blocked move leaves the position unchanged but still enters COOLDOWN.
- Win:
  - A legal move to row 0 sets pN_win and game_over on the same edge.
  - If both players reach row 0 on the same tick, both flags are set.
  - Once game_over=1, FSMs are held in IDLE, presses are ignored and positions are frozen until reset.
- No combinational path from any input to any output.

Optional Feature:
- Macro WRAP_X_EN.
- Defined: horizontal wrap. Left from x=0 targets x=15 and right from x=15 targets x=0. The tree and other-player checks still apply to the wrapped target.
- Undefined: those moves are blocked as out of bounds.
- Vertical bounds are never wrapped.

Test Plan:
All scenarios use bench parameters DEBOUNCE_CYCLES=4 and COOLDOWN_CYCLES=8.
1. Reset: hold rst=0 for 3 clks -> player_x=7, player_y=11, player_2x=8, player_2y=11, all flags 0. Reassert rst mid-cooldown -> same values, next press accepted immediately.
2. Debounce/latency: p1 up held 6 clks, frame_tick 10 clks later -> player_y 11->10 on the frame_tick edge only. A 2-clk glitch -> no move.
3. Cooldown: second p1 up press 3 clks after the move -> discarded, player_y stays 10. Same press 12 clks after the move -> applied on the next frame_tick, player_y=9.
4. Blocking:
   - p2 left from (8,11) while p1 sits at (7,11) -> player_2x stays 8.
   - p1 at (2,2) presses up -> moves to (2,1); then p1 left toward (1,1) (tree) -> stays (2,1).
   - p1 down from row 11 -> stays 11.
5. Same-tile contest: p1 at (5,4) presses right and p2 at (7,4) presses left, both pending on the same frame_tick -> p1 moves to (6,4), p2 stays at (7,4).
6. Win/wrap:
   - p1 at (2,1) presses up -> player_y=0, p1_win=1, game_over=1; later presses by either player change nothing.
   - With WRAP_X_EN, p2 at (0,5) presses left -> player_2x=15. Without WRAP_X_EN -> player_2x stays 0.
